cut_sequencer: RTL and testbench

CUT_SEQUENCER -- requirements
Module: cut_sequencer

---
 rtl/cut_sequencer.sv | 150 +++++++++++++++
 tb/tb_cut_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cut_sequencer.sv
// Slicer job sequencer: alternates feed and cut stepper requests per slice,
// with per-phase watchdog, abort and fault handling.
module cut_sequencer #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd100_000_000,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] num_cuts_i,
    output logic             feed_o,
    input  logic             feed_end_i,
    output logic             cut_o,
    input  logic             cut_end_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] cuts_left_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_CUT,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [31:0] TMO_LAST = TIMEOUT_CYC - 32'd1;

    state_t           state_q, state_d;
    logic [31:0]      timer_q, timer_d;
    logic [CNT_W-1:0] cuts_q, cuts_d;
    logic             start_prev_q, feed_end_prev_q, cut_end_prev_q;
    logic             feed_q, feed_d;
    logic             cut_q, cut_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             start_edge, feed_edge, cut_edge, expired;

    always_comb begin
        start_edge = start_i & ~start_prev_q;
        feed_edge  = feed_end_i & ~feed_end_prev_q;
        cut_edge   = cut_end_i & ~cut_end_prev_q;
        expired    = (timer_q == TMO_LAST);
        state_d    = state_q;
        cuts_d     = cuts_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge && !abort_i) begin
                    if (num_cuts_i != '0) begin
                        state_d = S_FEED;
                        cuts_d  = num_cuts_i;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FEED: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cuts_d  = '0;
                end else if (feed_edge) begin
                    state_d = S_CUT;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_CUT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cuts_d  = '0;
                end else if (cut_edge) begin
                    cuts_d  = cuts_q - CNT_W'(1);
                    state_d = (cuts_q == CNT_W'(1)) ? S_DONE : S_FEED;
                end else if (expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cuts_d  = '0;
            end
            S_FAULT: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    cuts_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cuts_d  = '0;
            end
        endcase

        // Timer restarts on any transition, including CUT back into FEED.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == S_FEED || state_q == S_CUT) begin
            timer_d = timer_q + 32'd1;
        end else begin
            timer_d = '0;
        end

        feed_d = (state_d == S_FEED);
        cut_d  = (state_d == S_CUT);
        busy_d = (state_d == S_FEED) || (state_d == S_CUT);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            cuts_q          <= '0;
            start_prev_q    <= 1'b0;
            feed_end_prev_q <= 1'b0;
            cut_end_prev_q  <= 1'b0;
            feed_q          <= 1'b0;
            cut_q           <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            cuts_q          <= cuts_d;
            start_prev_q    <= start_i;
            feed_end_prev_q <= feed_end_i;
            cut_end_prev_q  <= cut_end_i;
            feed_q          <= feed_d;
            cut_q           <= cut_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_q           <= err_d;
        end
    end

    assign feed_o      = feed_q;
    assign cut_o       = cut_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign cuts_left_o = cuts_q;

endmodule

// File: tb/tb_cut_sequencer.sv
// Directed plus randomized job sequences for cut_sequencer, checked against
// expected job-level output patterns derived in the bench.
module tb_cut_sequencer;

    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       abort_i;
    logic [4:0] num_cuts_i;
    logic       feed_o;
    logic       feed_end_i;
    logic       cut_o;
    logic       cut_end_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic [4:0] cuts_left_o;

    int n_chk  = 0;
    int n_fail = 0;

    cut_sequencer #(
        .TIMEOUT_CYC(32'd20),
        .CNT_W      (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .num_cuts_i (num_cuts_i),
        .feed_o     (feed_o),
        .feed_end_i (feed_end_i),
        .cut_o      (cut_o),
        .cut_end_i  (cut_end_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .cuts_left_o(cuts_left_o)
    );

    always #5 clk = ~clk;

    // Observed vector: {feed, cut, busy, done, err, cuts_left}
    function automatic logic [9:0] obs();
        return {feed_o, cut_o, busy_o, done_o, err_o, cuts_left_o};
    endfunction

    function automatic logic [9:0] e_feed(int left);
        return {5'b10100, 5'(left)};
    endfunction

    function automatic logic [9:0] e_cut(int left);
        return {5'b01100, 5'(left)};
    endfunction

    localparam logic [9:0] E_IDLE  = 10'b00000_00000;
    localparam logic [9:0] E_DONE  = 10'b00010_00000;
    localparam logic [9:0] E_FAULT = 10'b00001_00000;
    localparam logic [9:0] M_ALL   = 10'b11111_11111;
    localparam logic [9:0] M_FLAGS = 10'b11111_00000;

    task automatic chk(input string tag, input logic [9:0] got,
                       input logic [9:0] exp, input logic [9:0] mask);
        n_chk++;
        assert ((got & mask) === (exp & mask))
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (mask %b)",
                   tag, got, exp, mask);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // One full job of n slices with random waits and stray ignored events.
    task automatic run_job(input int n);
        int d;
        int left;
        num_cuts_i = 5'(n);
        start_i    = 1'b1;
        step();
        chk("job_start", obs(), e_feed(n), M_ALL);
        start_i    = 1'b0;
        num_cuts_i = 5'($urandom);
        for (int i = 0; i < n; i++) begin
            left = n - i;
            d = $urandom_range(0, 4);
            repeat (d) begin
                if ($urandom_range(0, 1) == 1) cut_end_i = 1'b1;
                else start_i = 1'b1;
                step();
                chk("feed_wait", obs(), e_feed(left), M_ALL);
                cut_end_i = 1'b0;
                start_i   = 1'b0;
            end
            feed_end_i = 1'b1;
            step();
            chk("feed_end", obs(), e_cut(left), M_ALL);
            d = $urandom_range(0, 2);
            repeat (d) begin
                step();
                chk("feed_end_held", obs(), e_cut(left), M_ALL);
            end
            feed_end_i = 1'b0;
            d = $urandom_range(0, 4);
            repeat (d) begin
                start_i = $urandom_range(0, 1) == 1;
                step();
                chk("cut_wait", obs(), e_cut(left), M_ALL);
                start_i = 1'b0;
            end
            cut_end_i = 1'b1;
            step();
            chk("cut_end", obs(),
                (left == 1) ? E_DONE : e_feed(left - 1), M_ALL);
            cut_end_i = 1'b0;
        end
        step();
        chk("job_idle", obs(), E_IDLE, M_ALL);
    endtask

    initial begin
        rst        = 1'b1;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        num_cuts_i = 5'd0;
        feed_end_i = 1'b0;
        cut_end_i  = 1'b0;
        repeat (3) step();
        chk("reset", obs(), E_IDLE, M_ALL);
        rst = 1'b0;
        step();
        chk("idle_after_reset", obs(), E_IDLE, M_ALL);

        // Two-slice reference job.
        run_job(2);

        // Zero slices: straight to a single done pulse; held start is one event.
        num_cuts_i = 5'd0;
        start_i    = 1'b1;
        step();
        chk("zero_done", obs(), E_DONE, M_ALL);
        step();
        chk("zero_idle", obs(), E_IDLE, M_ALL);
        step();
        chk("zero_no_retrigger", obs(), E_IDLE, M_ALL);
        start_i = 1'b0;
        step();

        // Feed watchdog.
        num_cuts_i = 5'd1;
        start_i    = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            step();
            if (k == TMO - 1) chk("feed_tmo_last", obs(), e_feed(1), M_ALL);
        end
        step();
        chk("feed_tmo_fault", obs(), E_FAULT, M_FLAGS);
        start_i    = 1'b1;
        feed_end_i = 1'b1;
        cut_end_i  = 1'b1;
        step();
        chk("fault_sticky", obs(), E_FAULT, M_FLAGS);
        start_i    = 1'b0;
        feed_end_i = 1'b0;
        cut_end_i  = 1'b0;
        step();
        chk("fault_sticky2", obs(), E_FAULT, M_FLAGS);
        abort_i = 1'b1;
        step();
        chk("fault_abort", obs(), E_IDLE, M_ALL);
        abort_i = 1'b0;

        // Cut watchdog.
        num_cuts_i = 5'd2;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("cut_tmo_enter", obs(), e_cut(2), M_ALL);
        feed_end_i = 1'b0;
        repeat (TMO - 1) step();
        chk("cut_tmo_last", obs(), e_cut(2), M_ALL);
        step();
        chk("cut_tmo_fault", obs(), E_FAULT, M_FLAGS);
        abort_i = 1'b1;
        step();
        chk("cut_fault_abort", obs(), E_IDLE, M_ALL);
        abort_i = 1'b0;
        step();

        // cut_end held high for 5 cycles in a 3-slice job.
        num_cuts_i = 5'd3;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("hold_cut3", obs(), e_cut(3), M_ALL);
        feed_end_i = 1'b0;
        cut_end_i  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_feed2", obs(), e_feed(2), M_ALL);
        end
        cut_end_i  = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("hold_cut2", obs(), e_cut(2), M_ALL);
        feed_end_i = 1'b0;
        cut_end_i  = 1'b1;
        step();
        chk("hold_feed1", obs(), e_feed(1), M_ALL);
        cut_end_i  = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("hold_cut1", obs(), e_cut(1), M_ALL);
        feed_end_i = 1'b0;
        cut_end_i  = 1'b1;
        step();
        chk("hold_done", obs(), E_DONE, M_ALL);
        cut_end_i = 1'b0;
        step();
        chk("hold_idle", obs(), E_IDLE, M_ALL);

        // Abort wins over feed_end in FEED.
        num_cuts_i = 5'd4;
        start_i    = 1'b1;
        step();
        chk("abf_feed", obs(), e_feed(4), M_ALL);
        start_i    = 1'b0;
        abort_i    = 1'b1;
        feed_end_i = 1'b1;
        step();
        chk("abf_idle", obs(), E_IDLE, M_ALL);
        abort_i    = 1'b0;
        feed_end_i = 1'b0;
        step();
        chk("abf_no_done", obs(), E_IDLE, M_ALL);

        // Abort wins over cut_end in CUT.
        num_cuts_i = 5'd2;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("abc_cut", obs(), e_cut(2), M_ALL);
        feed_end_i = 1'b0;
        abort_i    = 1'b1;
        cut_end_i  = 1'b1;
        step();
        chk("abc_idle", obs(), E_IDLE, M_ALL);
        abort_i   = 1'b0;
        cut_end_i = 1'b0;
        step();
        chk("abc_no_done", obs(), E_IDLE, M_ALL);

        // Start coincident with abort in IDLE is dropped.
        num_cuts_i = 5'd3;
        abort_i    = 1'b1;
        start_i    = 1'b1;
        step();
        chk("start_abort", obs(), E_IDLE, M_ALL);
        abort_i = 1'b0;
        step();
        chk("start_abort_held", obs(), E_IDLE, M_ALL);
        start_i = 1'b0;
        step();

        // Reset mid-CUT, then a fresh job.
        num_cuts_i = 5'd3;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
        feed_end_i = 1'b1;
        step();
        chk("rst_cut", obs(), e_cut(3), M_ALL);
        feed_end_i = 1'b0;
        rst        = 1'b1;
        step();
        chk("rst_mid", obs(), E_IDLE, M_ALL);
        rst = 1'b0;
        step();
        chk("rst_no_done", obs(), E_IDLE, M_ALL);
        run_job(2);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 7));
            repeat ($urandom_range(0, 2)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
